// File: rtl/fir_pkg.sv
// Shared definitions for FIR output stages: default sample widths and the
// round-half-up / saturate helper used when narrowing a filter result.
package fir_pkg;

    localparam int FIR_IN_W  = 16;
    localparam int FIR_OUT_W = 8;

    // Working width of the helper; callers zero-extend their samples into it.
    localparam int RSS_W  = 32;
    localparam int RSS_XW = RSS_W + 1;

    typedef struct packed {
        logic             sat;
        logic [RSS_W-1:0] value;
    } rss_t;

    // One extra guard bit above the sample keeps the half-LSB add from wrapping.
    function automatic rss_t round_shift_sat(
        input logic [RSS_W-1:0] x,
        input int               shift,
        input int               out_w
    );
        logic [RSS_XW-1:0] s;
        logic [RSS_XW-1:0] max_val;
        rss_t              r;
        s       = ({1'b0, x} + (RSS_XW'(1) << (shift - 1))) >> shift;
        max_val = (RSS_XW'(1) << out_w) - RSS_XW'(1);
        if (s > max_val) begin
            r.sat   = 1'b1;
            r.value = max_val[RSS_W-1:0];
        end else begin
            r.sat   = 1'b0;
            r.value = s[RSS_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_out_decimator_if.sv
// Valid/ready sample stream leaving the decimator; the producer side owns
// data and valid, the consumer side owns ready.
interface fir_out_decimator_if
    import fir_pkg::*;
#(
    parameter int OUT_W = FIR_OUT_W
);

    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Small single-clock FIFO with registered head; pointers carry one extra
// wrap bit so full and empty are told apart without an occupancy counter.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    // Flush only rewinds the pointers; stale memory is never presented as valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/fir_out_decimator.sv
// Output stage behind simple_fir: keeps one of every DECIM samples, rounds and
// saturates it to OUT_W bits, and queues it on a valid/ready stream.
module fir_out_decimator
    import fir_pkg::*;
#(
    parameter int IN_W  = FIR_IN_W,
    parameter int OUT_W = FIR_OUT_W,
    parameter int DECIM = 4,
    parameter int SHIFT = 4,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 in_en,
    input  logic [IN_W-1:0]      y_in,
    fir_out_decimator_if.master  out_bus,
    output logic                 sat_sticky,
    output logic [7:0]           drop_cnt
);

    localparam int              PH_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

    logic [PH_W-1:0]  phase;
    logic             keep;
    logic             push;
    logic             pop;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    rss_t             scaled;
    logic [OUT_W-1:0] push_val;
    logic             unused_scaled_hi;

    assign keep     = in_en && (phase == PH_LAST);
    assign scaled   = round_shift_sat(RSS_W'(y_in), SHIFT, OUT_W);
    assign push_val = scaled.value[OUT_W-1:0];

    // Upper bits are already folded into the saturation decision.
    assign unused_scaled_hi = ^scaled.value[RSS_W-1:OUT_W];

    // A full FIFO still accepts a sample when the consumer frees a slot this cycle.
    assign pop  = out_bus.out_valid && out_bus.out_ready;
    assign push = keep && (!fifo_full || pop);
    assign drop = keep && fifo_full && !pop;

    assign out_bus.out_valid = !fifo_empty;

    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .din   (push_val),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (out_bus.out_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase      <= '0;
            sat_sticky <= 1'b0;
            drop_cnt   <= '0;
        end else if (clr) begin
            phase      <= '0;
            sat_sticky <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            if (in_en) begin
                phase <= keep ? '0 : phase + PH_W'(1);
            end
            if (push && scaled.sat) begin
                sat_sticky <= 1'b1;
            end
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_fir_out_decimator.sv
// Randomised scoreboard bench for fir_out_decimator against a queue-based
// model of decimation, rounding, saturation and FIFO flow control.
module tb_fir_out_decimator;

    localparam int DECIM = 4;
    localparam int SHIFT = 4;
    localparam int DEPTH = 4;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       clr    = 1'b0;
    logic       in_en  = 1'b0;
    logic [15:0] y_in  = '0;
    logic       sat_sticky;
    logic [7:0] drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    int exp_q[$];
    int model_drop = 0;
    bit model_sat  = 1'b0;
    int in_cnt     = 0;

    bit pend_push = 1'b0;
    bit pend_drop = 1'b0;
    bit pend_sat  = 1'b0;
    bit pend_clr  = 1'b0;
    int pend_val  = 0;

    fir_out_decimator_if #(.OUT_W(8)) out_bus ();

    fir_out_decimator #(
        .IN_W  (16),
        .OUT_W (8),
        .DECIM (DECIM),
        .SHIFT (SHIFT),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .in_en      (in_en),
        .y_in       (y_in),
        .out_bus    (out_bus),
        .sat_sticky (sat_sticky),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Apply the model effect of the edge that just happened.
    task automatic commit_pending();
        if (pend_clr) begin
            exp_q.delete();
            model_drop = 0;
            model_sat  = 1'b0;
        end else begin
            if (pend_push) begin
                exp_q.push_back(pend_val);
                if (pend_sat) model_sat = 1'b1;
            end
            if (pend_drop && model_drop < 255) model_drop++;
        end
        pend_push = 1'b0;
        pend_drop = 1'b0;
        pend_sat  = 1'b0;
        pend_clr  = 1'b0;
    endtask

    // Drive one cycle of inputs and predict what the coming edge does.
    task automatic apply_stimulus(input bit en, input int y, input bit rdy, input bit cl);
        bit keep;
        bit pop_will;
        bit full;
        int v;
        @(posedge clk);
        #1;
        commit_pending();
        #1;
        in_en             = en;
        y_in              = 16'(y);
        out_bus.out_ready = rdy;
        clr               = cl;
        pend_clr          = cl;
        if (cl) begin
            in_cnt = 0;
        end else if (en) begin
            keep = (in_cnt % DECIM) == (DECIM - 1);
            in_cnt++;
            if (keep) begin
                v        = (y + (1 << (SHIFT - 1))) >> SHIFT;
                pop_will = (exp_q.size() > 0) && rdy;
                full     = exp_q.size() >= DEPTH;
                if (!full || pop_will) begin
                    pend_push = 1'b1;
                    pend_sat  = v > 255;
                    pend_val  = (v > 255) ? 255 : v;
                end else begin
                    pend_drop = 1'b1;
                end
            end
        end
    endtask

    task automatic keep_sample(input int y, input bit fill_rdy, input bit keep_rdy);
        for (int i = 0; i < DECIM - 1; i++) begin
            apply_stimulus(1'b1, $urandom_range(0, 65535), fill_rdy, 1'b0);
        end
        apply_stimulus(1'b1, y, keep_rdy, 1'b0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(1'b0, 0, rdy, 1'b0);
        end
    endtask

    task automatic reset_mid_op();
        @(posedge clk);
        #1;
        commit_pending();
        #1;
        in_en      = 1'b0;
        clr        = 1'b0;
        reset      = 1'b0;
        exp_q.delete();
        model_drop = 0;
        model_sat  = 1'b0;
        in_cnt     = 0;
        #1;
        check_output("async_rst_valid", out_bus.out_valid, 0);
        check_output("async_rst_data", out_bus.out_data, 0);
        check_output("async_rst_drop", drop_cnt, 0);
        check_output("async_rst_sat", sat_sticky, 0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    // Monitor: compares the DUT against the scoreboard every cycle.
    initial begin
        forever begin
            @(negedge clk);
            check_output("out_valid", out_bus.out_valid, exp_q.size() > 0);
            check_output("drop_cnt", drop_cnt, model_drop);
            check_output("sat_sticky", sat_sticky, model_sat);
            if (out_bus.out_valid && out_bus.out_ready && exp_q.size() > 0) begin
                check_output("out_data", out_bus.out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        out_bus.out_ready = 1'b0;
        #1;
        check_output("reset_valid", out_bus.out_valid, 0);
        check_output("reset_data", out_bus.out_data, 0);
        check_output("reset_drop", drop_cnt, 0);
        check_output("reset_sat", sat_sticky, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;

        $display("[TB] decimation");
        apply_stimulus(1'b1, 16, 1'b1, 1'b0);
        apply_stimulus(1'b1, 32, 1'b1, 1'b0);
        apply_stimulus(1'b1, 48, 1'b1, 1'b0);
        apply_stimulus(1'b1, 64, 1'b1, 1'b0);
        idle(3, 1'b1);

        $display("[TB] rounding");
        keep_sample(23, 1'b1, 1'b1);
        keep_sample(24, 1'b1, 1'b1);
        keep_sample(40, 1'b1, 1'b1);
        idle(2, 1'b1);

        $display("[TB] saturation");
        keep_sample(65535, 1'b1, 1'b1);
        keep_sample(40, 1'b1, 1'b1);
        idle(2, 1'b1);

        $display("[TB] backpressure");
        apply_stimulus(1'b0, 0, 1'b0, 1'b1);
        for (int k = 1; k <= 5; k++) keep_sample(16 * k, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(6, 1'b1);

        $display("[TB] full with push and pop");
        apply_stimulus(1'b0, 0, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) keep_sample(16 * k, 1'b0, 1'b0);
        keep_sample(200, 1'b0, 1'b1);
        idle(6, 1'b1);

        $display("[TB] clr with drops pending");
        apply_stimulus(1'b0, 0, 1'b0, 1'b1);
        for (int k = 1; k <= 7; k++) keep_sample(100 * k, 1'b0, 1'b0);
        idle(2, 1'b0);
        apply_stimulus(1'b0, 0, 1'b0, 1'b1);
        idle(2, 1'b1);

        $display("[TB] reset mid-operation");
        apply_stimulus(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 2 * DECIM + 2; i++) apply_stimulus(1'b1, 16 * (i + 1), 1'b0, 1'b0);
        reset_mid_op();
        for (int i = 0; i < DECIM; i++) apply_stimulus(1'b1, 300 + i, 1'b1, 1'b0);
        idle(3, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            int y;
            y = ($urandom_range(0, 3) == 0) ? $urandom_range(4000, 65535) : $urandom_range(0, 4200);
            apply_stimulus($urandom_range(0, 3) != 0, y, $urandom_range(0, 9) < 6,
                           $urandom_range(0, 149) == 0);
        end
        idle(DEPTH + 4, 1'b1);
        idle(1, 1'b1);
        check_output("drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fir_out_decimator.md
# fir_out_decimator

Post-filter output stage that sits directly downstream of `simple_fir` and consumes its 16-bit `y_out` stream. It decimates the sample stream by a fixed ratio, rescales each kept sample with round-half-up, saturates it to 8 bits, and buffers the result in a small FIFO. The FIFO presents the samples on a valid/ready interface. Sticky saturation and drop statistics report numeric and flow-control health.

## Interface
Parameters:
- `IN_W`, 16, input sample width (unsigned, matches FIR `y_out`)
- `OUT_W`, 8, output sample width (unsigned)
- `DECIM`, 4, decimation ratio, ≥1; keep 1 of every `DECIM` accepted inputs
- `SHIFT`, 4, right-shift applied before saturation, ≥1
- `DEPTH`, 4, FIFO depth, power of two, ≥2

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; block is held in reset while low
- `clr`  in  1  synchronous flush, active-high
- `in_en`  in  1  `y_in` carries a new FIR sample this cycle
- `y_in`  in  `IN_W`  FIR output sample
- `out_data`  out  `OUT_W`  FIFO head sample
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  consumer accepts head this cycle
- `sat_sticky`  out  1  set when any pushed sample was saturated
- `drop_cnt`  out  8  count of decimated samples lost to a full FIFO; saturates at 255

## Operation
- **Phase counter.** A phase counter runs 0..`DECIM`-1 and advances on each `in_en` cycle, wrapping to 0.
- **Keep event.** A keep event is `in_en && phase == DECIM-1`. When `DECIM`=1, every `in_en` cycle is a keep event.
- **Scaling.** Compute in `IN_W`+1 bits: `s = (y_in + 2^(SHIFT-1)) >> SHIFT`. The result can never wrap.
- **Saturation.** If `s > 2^OUT_W - 1`, the pushed value is `2^OUT_W - 1` and `sat_sticky` is set. Otherwise the pushed value is `s[OUT_W-1:0]`.
- **Push.** The FIFO is pushed on a keep event unless it is full with no pop in the same cycle.
- **Drop.** A keep event into a full FIFO with no pop discards the sample and increments `drop_cnt`, which saturates at 255.
- **Pop.** The FIFO is popped on `out_valid && out_ready`.
- **Full with simultaneous push and pop.** Both happen; occupancy stays at `DEPTH`; no drop is counted.
- **Empty with a keep event and `out_ready`=1.** The new sample is not popped in the same cycle; there is no fall-through.
- **Output ordering.** `out_data` drives `mem[rd_ptr]`. Its value is don't-care when `out_valid`=0, but it must not be X after reset.
- **`clr` flush.** `clr`=1 returns the phase counter to 0, empties the FIFO, zeroes `drop_cnt` and clears `sat_sticky`. `clr` has priority over a push or pop in the same cycle; the push or pop is ignored.
- **Reset.** On `reset` low, all state is cleared asynchronously:
  - phase 0, FIFO pointers 0, FIFO memory 0
  - `out_valid`=0, `out_data`=0
  - `sat_sticky`=0, `drop_cnt`=0

## Timing
- **Sampling.** `y_in` and `in_en` are sampled on the rising edge of `clk`. The FIR's registered output connects directly with no extra alignment.
- **Latency.** A keep event at edge N makes the sample visible at `out_data` with `out_valid`=1 after edge N when the FIFO was empty. This is 1 cycle of latency.
- **Pop.** A pop at edge N presents the next entry, or deasserts `out_valid`, after edge N.
- **Flag updates.** `sat_sticky` and `drop_cnt` update at the same edge as the triggering keep event.
- **Reset assertion.** Asynchronous: outputs go to their reset values without waiting for a clock edge.
- **Reset release.** Deassertion is synchronous to the design. The first `in_en` edge after release counts as phase 0.
- **Handshake rule.** `out_valid` never deasserts without a pop, `clr` or reset. `out_data` is stable while `out_valid && !out_ready`.

## Structure
- **Shared package `fir_pkg`.**
  - Holds default widths `FIR_IN_W`=16 and `FIR_OUT_W`=8.
  - Holds the `round_shift_sat` function, parameterised by `SHIFT` and `OUT_W`, returning `{sat, value}`.
  - The function is shared with future FIR output stages.
- **Sub-module `sync_fifo`.**
  - Parameters: `WIDTH`, `DEPTH`.
  - Ports: push, pop, `clr`, full, empty, head.
  - Pointers are `log2(DEPTH)`+1 bits wide for full/empty detection.
  - Uses the same `clk` and active-low `reset`.
- **Top level.** Owns the phase counter, the scaling and saturation logic, the drop counter and the sticky flag.

## Test plan
(Defaults throughout: `DECIM`=4, `SHIFT`=4, `DEPTH`=4.)
- **Decimation:** `in_en`=1 continuously with `y_in`=16,32,48,64 and `out_ready`=1 → exactly one output, value 4 = (64+8)>>4, visible one cycle after the 64 edge.
- **Rounding:** keep samples 23, 24, 40 → outputs 1, 2, 3; `sat_sticky` stays 0.
- **Saturation:** keep sample 65535 → `out_data`=255 and `sat_sticky`=1. `sat_sticky` remains 1 through later in-range samples until `clr` or reset.
- **Backpressure:** `out_ready`=0, five keep samples 16,32,48,64,80 → `out_valid`=1 with head 1, and `drop_cnt`=1. Then `out_ready`=1 → outputs 1,2,3,4 in order, then `out_valid`=0.
- **Full with push and pop:** FIFO holding 4 entries, keep event and `out_ready`=1 in the same cycle → `drop_cnt` unchanged; the new sample appears fourth in line.
- **Reset and clr mid-operation:**
  - `reset` low with 2 entries queued and phase=2 → `out_valid`=0 immediately, without a clock edge.
  - After release, the first keep event occurs on the 4th `in_en`.
  - `clr` with `drop_cnt`=3 → `drop_cnt`=0 on the next edge.
